// File: rtl/systolic_drain_pkg.sv
// systolic_pkg: shared types and constants for the systolic drain stage.
//   drain_state_t   : drain FSM state encoding (IDLE, DRAIN)
//   DEF_DATA_WIDTH  : default output sample width
//   DEF_ACC_WIDTH   : default PE accumulator width (4x sample width)
//   sat_max()       : largest unsigned value representable in 'width' bits
package systolic_pkg;

    typedef enum logic {IDLE, DRAIN} drain_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 4 * DEF_DATA_WIDTH;

    function automatic logic [63:0] sat_max(input int unsigned width);
        if (width >= 64) begin
            sat_max = '1;
        end else begin
            sat_max = (64'd1 << width) - 64'd1;
        end
    endfunction

endpackage

// File: rtl/systolic_drain_if.sv
// systolic_drain_if: result stream from the drain stage to the output buffer.
//   out_valid : sample on out_data is valid           (master -> slave)
//   out_ready : downstream can accept a sample        (slave -> master)
//   out_data  : requantised sample                    (master -> slave)
//   out_last  : sample is the final element of column (master -> slave)
// Handshake: a transfer happens on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_valid, out_data and
// out_last stay unchanged until that transfer; out_ready may toggle freely.
interface systolic_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/systolic_drain_requant_sat.sv
// requant_sat: combinational requantiser. Right-shifts an unsigned
// accumulator by shamt and saturates the result to DATA_WIDTH bits.
//   acc   : unsigned accumulator value
//   shamt : right-shift amount; any amount >= ACC_WIDTH yields 0
//   data  : saturated result
// Build option: SYSTOLIC_DRAIN_ROUND_EN adds round-half-up before the shift.
module requant_sat
    import systolic_pkg::*;
#(
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SHIFT_W    = 6
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [SHIFT_W-1:0]    shamt,
    output logic [DATA_WIDTH-1:0] data
);
    // One extra bit so the rounding add can never wrap.
    localparam logic [ACC_WIDTH:0] MAX_OUT = (ACC_WIDTH+1)'(sat_max(DATA_WIDTH));

    logic [ACC_WIDTH:0] sum;
    logic [ACC_WIDTH:0] y;

    always_comb begin
        sum = {1'b0, acc};
`ifdef SYSTOLIC_DRAIN_ROUND_EN
        if (shamt != '0) begin
            sum = {1'b0, acc} + ((ACC_WIDTH+1)'(1) << (shamt - SHIFT_W'(1)));
        end
`endif
        // Oversized shifts flush to zero in both rounding modes.
        if (int'(shamt) >= ACC_WIDTH) begin
            y = '0;
        end else begin
            y = sum >> shamt;
        end
        if (y > MAX_OUT) begin
            data = '1;
        end else begin
            data = y[DATA_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: captures a column of N PE accumulators on 'load', clears
// the PE array, and streams the requantised results out one per transfer.
//   clk, rst  : clock, synchronous active-high reset
//   acc_in    : N unsigned accumulators, element i at [i*ACC_WIDTH +: ACC_WIDTH]
//   load      : capture request; accepted in IDLE or on the final transfer
//   shift     : requantisation shift, sampled with an accepted load
//   out_if    : result stream (valid/ready/data/last)
//   clr_pe    : one-cycle PE clear after a capture
//   busy      : high while draining
//   overrun   : one-cycle pulse when a load is rejected
//   state_dbg : current FSM state
// Build option: SYSTOLIC_DRAIN_ROUND_EN enables round-half-up in requant_sat.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N          = 4,
    parameter int ACC_WIDTH  = 4 * DATA_WIDTH,
    parameter int SHIFT_W    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*ACC_WIDTH-1:0] acc_in,
    input  logic                   load,
    input  logic [SHIFT_W-1:0]     shift,
    systolic_drain_if.master       out_if,
    output logic                   clr_pe,
    output logic                   busy,
    output logic                   overrun,
    output drain_state_t           state_dbg
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    drain_state_t         state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [ACC_WIDTH-1:0] shadow_q [N];
    logic [ACC_WIDTH-1:0] shadow_d [N];
    logic                 clr_pe_q, clr_pe_d;
    logic                 overrun_q, overrun_d;

    logic out_valid;
    logic at_last;
    logic fire;
    logic accept;

    // The stream is valid for exactly as long as the FSM sits in DRAIN.
    assign out_valid = (state_q == DRAIN);
    assign at_last   = (idx_q == LAST_IDX);
    assign fire      = out_valid & out_if.out_ready;
    // Accepting on the final transfer gives back-to-back columns with no bubble.
    assign accept    = load & ((state_q == IDLE) | (fire & at_last));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        shadow_d  = shadow_q;
        clr_pe_d  = 1'b0;
        overrun_d = load & ~accept;

        if (accept) begin
            for (int i = 0; i < N; i++) begin
                shadow_d[i] = acc_in[i*ACC_WIDTH +: ACC_WIDTH];
            end
            shift_d  = shift;
            idx_d    = '0;
            state_d  = DRAIN;
            clr_pe_d = 1'b1;
        end else if (fire) begin
            if (at_last) begin
                idx_d   = '0;
                state_d = IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            shift_q   <= '0;
            clr_pe_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            clr_pe_q  <= clr_pe_d;
            overrun_q <= overrun_d;
            shadow_q  <= shadow_d;
        end
    end

    requant_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .SHIFT_W   (SHIFT_W)
    ) u_requant (
        .acc  (shadow_q[idx_q]),
        .shamt(shift_q),
        .data (out_if.out_data)
    );

    assign out_if.out_valid = out_valid;
    assign out_if.out_last  = out_valid & at_last;
    assign clr_pe           = clr_pe_q;
    assign busy             = out_valid;
    assign overrun          = overrun_q;
    assign state_dbg        = state_q;
endmodule

// File: tb/tb_systolic_drain.sv
module tb_systolic_drain;
  import systolic_pkg::*;

  localparam int DW = 8;
  localparam int NN = 4;
  localparam int AW = 32;
  localparam int SW = 6;

  typedef struct packed {
    logic [NN-1:0][AW-1:0] acc;
    logic [SW-1:0]         sh;
    logic [NN-1:0][DW-1:0] exp;
  } vec_t;

  logic                clk;
  logic                rst;
  logic [NN*AW-1:0]    acc_in;
  logic                load;
  logic [SW-1:0]       shift;
  logic                clr_pe;
  logic                busy;
  logic                overrun;
  drain_state_t        state_dbg;

  int checks;
  int failures;

  systolic_drain_if #(.DATA_WIDTH(DW)) sif ();

  systolic_drain #(
    .DATA_WIDTH(DW),
    .N         (NN),
    .ACC_WIDTH (AW),
    .SHIFT_W   (SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .acc_in   (acc_in),
    .load     (load),
    .shift    (shift),
    .out_if   (sif),
    .clr_pe   (clr_pe),
    .busy     (busy),
    .overrun  (overrun),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Check every output at a negedge for one cycle of an active drain.
  task automatic chk_elem(input string tag, input logic [DW-1:0] d, input logic last, input logic clr);
    chk({tag, " valid"}, 32'(sif.out_valid), 32'd1);
    chk({tag, " data"}, 32'(sif.out_data), 32'(d));
    chk({tag, " last"}, 32'(sif.out_last), 32'(last));
    chk({tag, " clr_pe"}, 32'(clr_pe), 32'(clr));
    chk({tag, " busy"}, 32'(busy), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " idle valid"}, 32'(sif.out_valid), 32'd0);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle last"}, 32'(sif.out_last), 32'd0);
    chk({tag, " idle clr_pe"}, 32'(clr_pe), 32'd0);
  endtask

  // Driver: called at a negedge; loads a column and drains it with ready high.
  task automatic drain_vec(input vec_t v, input string tag);
    acc_in = v.acc;
    shift = v.sh;
    load = 1'b1;
    sif.out_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < NN; k++) begin
      if (k > 0) @(negedge clk);
      chk_elem($sformatf("%s e%0d", tag, k), v.exp[k], k == NN - 1, k == 0);
    end
    @(negedge clk);
    chk_idle(tag);
  endtask

  task automatic start_load(input logic [NN-1:0][AW-1:0] acc, input logic [SW-1:0] sh);
    acc_in = acc;
    shift = sh;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    load = 1'b0;
    acc_in = '0;
    shift = '0;
    sif.out_ready = 1'b0;

    vecs[0] = '{acc: {32'd40, 32'd30, 32'd20, 32'd10}, sh: 6'd0,
                exp: {8'd40, 8'd30, 8'd20, 8'd10}};
`ifdef SYSTOLIC_DRAIN_ROUND_EN
    vecs[1] = '{acc: {32'h0, 32'h200, 32'hFF, 32'h1234}, sh: 6'd1,
                exp: {8'd0, 8'd255, 8'd128, 8'd255}};
    vecs[3] = '{acc: {32'h0001_0000, 32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_AB00}, sh: 6'd8,
                exp: {8'd255, 8'd1, 8'd255, 8'hAB}};
    vecs[4] = '{acc: {32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000}, sh: 6'd31,
                exp: {8'd0, 8'd1, 8'd2, 8'd1}};
`else
    vecs[1] = '{acc: {32'h0, 32'h200, 32'hFF, 32'h1234}, sh: 6'd1,
                exp: {8'd0, 8'd255, 8'd127, 8'd255}};
    vecs[3] = '{acc: {32'h0001_0000, 32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_AB00}, sh: 6'd8,
                exp: {8'd255, 8'd0, 8'd255, 8'hAB}};
    vecs[4] = '{acc: {32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000}, sh: 6'd31,
                exp: {8'd0, 8'd0, 8'd1, 8'd1}};
`endif
    vecs[2] = '{acc: {32'h8000_0000, 32'h1, 32'h1234_5678, 32'hFFFF_FFFF}, sh: 6'd40,
                exp: {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[5] = '{acc: {32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF}, sh: 6'd32,
                exp: {8'd0, 8'd0, 8'd0, 8'd0}};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk_idle("reset");
    chk("reset data", 32'(sif.out_data), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);
    chk("reset state", 32'(state_dbg), 32'(IDLE));

    // table-driven drains
    for (int i = 0; i < 6; i++) begin
      drain_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // backpressure at element 1
    sif.out_ready = 1'b1;
    start_load({32'd8, 32'd7, 32'd6, 32'd5}, 6'd0);
    chk_elem("bp e0", 8'd5, 1'b0, 1'b1);
    @(negedge clk);
    chk_elem("bp e1", 8'd6, 1'b0, 1'b0);
    sif.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_elem($sformatf("bp hold%0d", k), 8'd6, 1'b0, 1'b0);
    end
    sif.out_ready = 1'b1;
    @(negedge clk);
    chk_elem("bp e2", 8'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk_elem("bp e3", 8'd8, 1'b1, 1'b0);
    @(negedge clk);
    chk_idle("bp");

    // overrun during element 1, then back-to-back load on the last fire
    start_load({32'd4, 32'd3, 32'd2, 32'd1}, 6'd0);
    chk_elem("ov e0", 8'd1, 1'b0, 1'b1);
    @(negedge clk);
    chk_elem("ov e1", 8'd2, 1'b0, 1'b0);
    acc_in = {32'd99, 32'd99, 32'd99, 32'd99};
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("ov pulse", 32'(overrun), 32'd1);
    chk_elem("ov e2", 8'd3, 1'b0, 1'b0);
    @(negedge clk);
    chk("ov pulse end", 32'(overrun), 32'd0);
    chk_elem("ov e3", 8'd4, 1'b1, 1'b0);
    acc_in = {32'd14, 32'd13, 32'd12, 32'd11};
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("b2b overrun", 32'(overrun), 32'd0);
    chk_elem("b2b e0", 8'd11, 1'b0, 1'b1);
    for (int k = 1; k < NN; k++) begin
      @(negedge clk);
      chk_elem($sformatf("b2b e%0d", k), 8'(11 + k), k == NN - 1, 1'b0);
    end
    @(negedge clk);
    chk_idle("b2b");

    // reset mid-drain at element 2
    start_load({32'd24, 32'd23, 32'd22, 32'd21}, 6'd0);
    chk_elem("rs e0", 8'd21, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk_elem("rs e2", 8'd23, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rs");
    chk("rs data", 32'(sif.out_data), 32'd0);
    start_load({32'd34, 32'd33, 32'd32, 32'd31}, 6'd0);
    for (int k = 0; k < NN; k++) begin
      if (k > 0) @(negedge clk);
      chk_elem($sformatf("rs2 e%0d", k), 8'(31 + k), k == NN - 1, k == 0);
    end
    @(negedge clk);
    chk_idle("rs2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Downstream stage of the systolic PE array. Captures one column of N PE accumulators on a load pulse and clears the PEs.
- Serialises the N results, requantised and saturated to DATA_WIDTH, over a valid/ready stream to the output buffer or filter post-processing.
- Frees the array to start the next tile while the previous column drains.

Parameters:
- DATA_WIDTH, 8, output sample width (matches PE operand width).
- N, 4, number of accumulators captured per load (PE rows).
- ACC_WIDTH, 4*DATA_WIDTH, width of each PE accumulator.
- SHIFT_W, 6, width of the requantisation shift amount.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- acc_in  input  N*ACC_WIDTH  PE accumulator column; element i in bits [i*ACC_WIDTH +: ACC_WIDTH], unsigned.
- load  input  1  one-cycle request to capture acc_in.
- shift  input  SHIFT_W  right-shift amount; sampled only on an accepted load.
- out_ready  input  1  downstream ready.
- out_valid  output  1  out_data valid.
- out_data  output  DATA_WIDTH  requantised sample.
- out_last  output  1  high with element N-1.
- clr_pe  output  1  one-cycle clear pulse to the PE array.
- busy  output  1  high while in DRAIN.
- overrun  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- All state is updated on posedge clk. rst has priority over every other input.
- Reset values: out_valid=0, out_data=0, out_last=0, clr_pe=0, busy=0, overrun=0, idx=0, state=IDLE, shadow registers=0.
- States: IDLE, DRAIN.
- Load acceptance: a load is accepted when state==IDLE, or when state==DRAIN and the final element fires in the same cycle (out_valid & out_ready & out_last). The final-fire case is back-to-back operation with no bubble.
- On accepted load, in the next cycle:
  - acc_in is copied into N shadow registers; shift is copied to shift_q; idx=0.
  - state=DRAIN; clr_pe=1 for exactly one cycle.
  - out_valid=1 and out_data=requant(shadow[0]). Latency from load to first valid is 1 cycle.
- Load in DRAIN without the final fire is ignored: no capture, no clr_pe, overrun=1 for one cycle. Shadow registers and drain progress are unaffected.
- Handshake:
  - Fire = out_valid & out_ready.
  - out_data, out_last and out_valid are held stable while out_valid & !out_ready.
  - On fire with idx<N-1: idx increments and out_data updates to the next element in the following cycle.
  - On fire with idx==N-1 and no accepted load: out_valid=0, state=IDLE.
- out_last = out_valid & (idx==N-1). busy = (state==DRAIN).
- requant(x), unsigned:
  - y = x >> shift_q, logical shift. shift_q >= ACC_WIDTH gives y=0.
  - If y > 2^DATA_WIDTH-1, out_data is all ones; otherwise out_data = y[DATA_WIDTH-1:0].
- Reset mid-drain returns to IDLE and discards remaining elements; clr_pe is not asserted.
- N=1: the first element is also the last.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_ROUND_EN.
- Defined: round-half-up before shifting. When shift_q>0, y = (x + 2^(shift_q-1)) >> shift_q. The sum is computed in ACC_WIDTH+1 bits so it cannot wrap; saturation is applied afterwards.
- Undefined: plain truncating shift as above.

Decomposition:
- Package systolic_pkg holds:
  - typedef enum logic {IDLE, DRAIN} drain_state_t;
  - localparam defaults for DATA_WIDTH and ACC_WIDTH (4*DATA_WIDTH);
  - a saturating-max constant function.
- Sub-module requant_sat: purely combinational shift, optional round and saturate, parameterised by ACC_WIDTH, DATA_WIDTH and SHIFT_W. It is instantiated once on the shadow element selected by idx.

Test Plan:
- Basic drain: N=4, acc_in={40,30,20,10} (elem0=10), shift=0, load, out_ready=1 -> clr_pe pulses the cycle after load; outputs 10,20,30,40 on 4 consecutive cycles; out_last only with 40; busy falls after.
- Saturation and shift: elements {0x0000_1234, 0x0000_00FF, 0x0000_0200, 0}, shift=1 -> 255 (sat), 127, 255 (0x100 sat), 0. With SYSTOLIC_DRAIN_ROUND_EN: second element -> 128.
- Backpressure: out_ready low for 3 cycles at element 1 -> out_data and out_valid held constant, idx unchanged; resumes with element 2 after ready returns.
- Overrun and back-to-back: load during element 1 -> overrun pulses once, sequence intact. Load coincident with the last fire -> next cycle shows new element 0 with out_valid continuously high and clr_pe=1.
- Reset mid-drain: assert rst at element 2 -> next cycle out_valid=0, busy=0, out_data=0; a subsequent load drains a fresh column from element 0.
- Large shift: shift=40 with ACC_WIDTH=32 -> all outputs 0, no X.
